// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor:
// saturating-counter states, counter type, default table size and PC step.
package branch_predictor_pkg;

    // 2-bit saturating direction counter
    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_SNT = 2'd0;
    localparam bp_ctr_t BP_WNT = 2'd1;
    localparam bp_ctr_t BP_WT  = 2'd2;
    localparam bp_ctr_t BP_ST  = 2'd3;

    localparam int BP_ENTRIES_DEFAULT = 64;

    // Sequential fetch step
    localparam logic [31:0] INST_LENTH = 32'd4;

    // Counter MSB is the taken prediction
    function automatic logic bp_pred_taken(input bp_ctr_t ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute resolution report and redirect request bundle.
// master = pipeline side, slave = predictor.
interface branch_predictor_if;

    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic [31:0] f_pred_target;
    logic [31:0] f_pred_npc;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_br;
    logic        ex_is_br_taken;
    logic        ex_is_jump;
    logic [31:0] ex_dnpc;
    logic [31:0] ex_pred_npc;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output f_pc,
        input  f_pred_taken, f_pred_target, f_pred_npc,
        output ex_valid, ex_pc, ex_is_br, ex_is_br_taken, ex_is_jump,
               ex_dnpc, ex_pred_npc,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  f_pc,
        output f_pred_taken, f_pred_target, f_pred_npc,
        input  ex_valid, ex_pc, ex_is_br, ex_is_br_taken, ex_is_jump,
               ex_dnpc, ex_pred_npc,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/branch_predictor_sat_ctr.sv
// bp_sat_ctr: combinational 2-bit saturating counter step.
module bp_sat_ctr
    import branch_predictor_pkg::*;
(
    input  bp_ctr_t ctr_i,
    input  logic    taken_i,
    output bp_ctr_t ctr_o
);

    // Move one step toward the resolved direction, clamping at SNT/ST
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != BP_ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != BP_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped 2-bit counter table + BTB next-PC predictor.
// Lookup is combinational on f_pc; training and the mispredict redirect come
// from the execute report. Optional statistics counters with BP_STATS_EN.
// ENTRIES must be a power of two, at least 4.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bus
`ifdef BP_STATS_EN
    ,
    output logic [31:0]        stat_br_cnt,
    output logic [31:0]        stat_mispred_cnt
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    bp_ctr_t            ctr_q    [ENTRIES];
    bp_ctr_t            ctr_d    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];

    logic               redirect_valid_q, redirect_valid_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;

    logic [IDX_W-1:0]   f_idx, ex_idx;
    logic [TAG_W-1:0]   f_tag, ex_tag;
    logic               f_hit, ex_hit;
    logic [31:0]        f_seq_pc;
    bp_ctr_t            ex_ctr_next;
    logic               mispred;

    logic               unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.f_pc[1:0], bus.ex_pc[1:0]};

    assign f_idx  = bus.f_pc[IDX_W+1:2];
    assign f_tag  = bus.f_pc[31:IDX_W+2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = bus.ex_pc[31:IDX_W+2];

    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Wraps modulo 2^32, so the last word of the address space yields 0
    assign f_seq_pc = bus.f_pc + INST_LENTH;

    // Lookup reads registered state only, so a same-cycle update is not seen
    assign bus.f_pred_taken  = f_hit && bp_pred_taken(ctr_q[f_idx]);
    assign bus.f_pred_target = f_hit ? target_q[f_idx] : f_seq_pc;
    assign bus.f_pred_npc    = bus.f_pred_taken ? bus.f_pred_target : f_seq_pc;

    bp_sat_ctr u_sat_ctr (
        .ctr_i   (ctr_q[ex_idx]),
        .taken_i (bus.ex_is_br_taken),
        .ctr_o   (ex_ctr_next)
    );

    // Table training from the execute report; a tag mismatch is a miss and
    // allocation simply evicts whatever lived at that index
    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (bus.ex_valid) begin
            if (bus.ex_is_jump) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = bus.ex_dnpc;
                ctr_d[ex_idx]    = BP_ST;
            end else if (bus.ex_is_br) begin
                if (ex_hit) begin
                    ctr_d[ex_idx] = ex_ctr_next;
                    if (bus.ex_is_br_taken) target_d[ex_idx] = bus.ex_dnpc;
                end else if (bus.ex_is_br_taken) begin
                    valid_d[ex_idx]  = 1'b1;
                    tag_d[ex_idx]    = ex_tag;
                    target_d[ex_idx] = bus.ex_dnpc;
                    ctr_d[ex_idx]    = BP_WT;
                end
            end
        end
    end

    // Any class whose resolved next PC differs from what fetch used redirects
    assign mispred = bus.ex_valid && (bus.ex_dnpc != bus.ex_pred_npc);

    // Redirect request next state; the PC holds between pulses
    always_comb begin
        redirect_valid_d = mispred;
        redirect_pc_d    = redirect_pc_q;
        if (mispred) redirect_pc_d = bus.ex_dnpc;
    end

    // Valid bits, counters and redirect register with async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q          <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BP_WNT;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
        end else begin
            valid_q          <= valid_d;
            ctr_q            <= ctr_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Tag and target storage is qualified by valid, so it needs no reset
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

`ifdef BP_STATS_EN
    logic [31:0] stat_br_cnt_q, stat_br_cnt_d;
    logic [31:0] stat_mispred_cnt_q, stat_mispred_cnt_d;

    // Free-running event counters, wrapping at 2^32
    always_comb begin
        stat_br_cnt_d      = stat_br_cnt_q;
        stat_mispred_cnt_d = stat_mispred_cnt_q;
        if (bus.ex_valid && (bus.ex_is_br || bus.ex_is_jump))
            stat_br_cnt_d = stat_br_cnt_q + 32'd1;
        if (mispred)
            stat_mispred_cnt_d = stat_mispred_cnt_q + 32'd1;
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_cnt_q      <= 32'h0;
            stat_mispred_cnt_q <= 32'h0;
        end else begin
            stat_br_cnt_q      <= stat_br_cnt_d;
            stat_mispred_cnt_q <= stat_mispred_cnt_d;
        end
    end

    assign stat_br_cnt      = stat_br_cnt_q;
    assign stat_mispred_cnt = stat_mispred_cnt_q;
`endif

`ifndef SYNTHESIS
    // A report cannot be both a conditional branch and a jump
    a_br_jump_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n)
        bus.ex_valid |-> !(bus.ex_is_br && bus.ex_is_jump)
    );
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a vector table of execute reports with
// the expected redirect and a post-update lookup, plus hand-written sequences
// for same-cycle lookup/update, mid-run reset and (with BP_STATS_EN) stats.
module tb_branch_predictor;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    branch_predictor_if bus ();

`ifdef BP_STATS_EN
    logic [31:0] stat_br_cnt, stat_mispred_cnt;
`endif

    branch_predictor #(.ENTRIES(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BP_STATS_EN
        ,
        .stat_br_cnt      (stat_br_cnt),
        .stat_mispred_cnt (stat_mispred_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        br;
        logic        tk;
        logic        jmp;
        logic [31:0] dnpc;
        logic [31:0] pnpc;
        logic [31:0] chk_pc;
        logic        e_tk;
        logic [31:0] e_npc;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [31:0] pc, logic br, logic tk,
                                logic jmp, logic [31:0] dnpc, logic [31:0] pnpc,
                                logic [31:0] chk_pc, logic e_tk, logic [31:0] e_npc,
                                logic e_rv, logic [31:0] e_rpc);
        vec_t r;
        r.v = v; r.pc = pc; r.br = br; r.tk = tk; r.jmp = jmp;
        r.dnpc = dnpc; r.pnpc = pnpc; r.chk_pc = chk_pc;
        r.e_tk = e_tk; r.e_npc = e_npc; r.e_rv = e_rv; r.e_rpc = e_rpc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic br,
                            input logic tk, input logic jmp, input logic [31:0] dnpc,
                            input logic [31:0] pnpc);
        bus.ex_valid       = v;
        bus.ex_pc          = pc;
        bus.ex_is_br       = br;
        bus.ex_is_br_taken = tk;
        bus.ex_is_jump     = jmp;
        bus.ex_dnpc        = dnpc;
        bus.ex_pred_npc    = pnpc;
    endtask

    task automatic chk_lookup(input string name, input logic e_tk, input logic [31:0] e_npc);
        chk({name, ".taken"}, {31'h0, bus.f_pred_taken}, {31'h0, e_tk});
        chk({name, ".npc"}, bus.f_pred_npc, e_npc);
        if (e_tk) chk({name, ".target"}, bus.f_pred_target, e_npc);
    endtask

    initial begin
        // ex_pc, br, tk, jmp, dnpc, pred_npc | chk_pc -> taken, npc | redirect
        // 0x100/0x200/0x300/0x400 all map to index 0 with tags 1/2/3/4
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 32'h080, 32'h104, 32'h100, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(1, 32'h100, 1, 0, 0, 32'h104, 32'h080, 32'h100, 0, 32'h104, 1, 32'h104));
        vecs.push_back(mk(1, 32'h100, 1, 0, 0, 32'h104, 32'h104, 32'h100, 0, 32'h104, 0, 32'h0));
        vecs.push_back(mk(1, 32'h100, 1, 0, 0, 32'h104, 32'h104, 32'h100, 0, 32'h104, 0, 32'h0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 32'h080, 32'h104, 32'h100, 0, 32'h104, 1, 32'h080));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 32'h090, 32'h104, 32'h100, 1, 32'h090, 1, 32'h090));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 32'h090, 32'h090, 32'h100, 1, 32'h090, 0, 32'h0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 32'h090, 32'h090, 32'h100, 1, 32'h090, 0, 32'h0));
        vecs.push_back(mk(1, 32'h100, 1, 0, 0, 32'h104, 32'h090, 32'h100, 1, 32'h090, 1, 32'h104));
        vecs.push_back(mk(1, 32'h200, 0, 0, 1, 32'h400, 32'h204, 32'h200, 1, 32'h400, 1, 32'h400));
        vecs.push_back(mk(0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   32'h100, 0, 32'h104, 0, 32'h0));
        vecs.push_back(mk(1, 32'h300, 1, 0, 0, 32'h304, 32'h304, 32'h300, 0, 32'h304, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   32'h200, 1, 32'h400, 0, 32'h0));
        vecs.push_back(mk(1, 32'h300, 1, 1, 0, 32'h500, 32'h304, 32'h300, 1, 32'h500, 1, 32'h500));
        vecs.push_back(mk(0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   32'h200, 0, 32'h204, 0, 32'h0));
        vecs.push_back(mk(1, 32'h200, 0, 0, 1, 32'h400, 32'h204, 32'h200, 1, 32'h400, 1, 32'h400));
        vecs.push_back(mk(1, 32'h200, 1, 0, 0, 32'h204, 32'h400, 32'h200, 1, 32'h400, 1, 32'h204));
        vecs.push_back(mk(1, 32'h200, 0, 0, 0, 32'h1000, 32'h204, 32'h200, 1, 32'h400, 1, 32'h1000));
        vecs.push_back(mk(0, 32'h0,   0, 0, 0, 32'h8,   32'h4,   32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0));

        rst_n  = 1'b0;
        bus.f_pc = 32'h100;
        drive_ex(0, 0, 0, 0, 0, 0, 0);
        #3;
        chk_lookup("reset_lookup", 1'b0, 32'h104);
        chk("reset_rv", {31'h0, bus.redirect_valid}, 32'h0);
        chk("reset_rpc", bus.redirect_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive_ex(vecs[i].v, vecs[i].pc, vecs[i].br, vecs[i].tk, vecs[i].jmp,
                     vecs[i].dnpc, vecs[i].pnpc);
            bus.f_pc = vecs[i].chk_pc;
            @(posedge clk);
            #1;
            bus.ex_valid = 1'b0;
            #1;
            chk_lookup($sformatf("vec%0d", i), vecs[i].e_tk, vecs[i].e_npc);
            chk($sformatf("vec%0d.rv", i), {31'h0, bus.redirect_valid}, {31'h0, vecs[i].e_rv});
            if (vecs[i].e_rv) chk($sformatf("vec%0d.rpc", i), bus.redirect_pc, vecs[i].e_rpc);
        end

        // Same-index lookup during an update sees the old contents
        @(negedge clk);
        drive_ex(1, 32'h400, 0, 0, 1, 32'h800, 32'h404);
        bus.f_pc = 32'h400;
        #1;
        chk_lookup("nobypass_pre", 1'b0, 32'h404);
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        #1;
        chk_lookup("nobypass_post", 1'b1, 32'h800);
        chk("nobypass_rv", {31'h0, bus.redirect_valid}, 32'h1);
        chk("nobypass_rpc", bus.redirect_pc, 32'h800);

        // Mid-cycle reset drops the pending redirect and the table at once
        rst_n = 1'b0;
        #1;
        chk("midrst_rv", {31'h0, bus.redirect_valid}, 32'h0);
        chk("midrst_rpc", bus.redirect_pc, 32'h0);
        chk_lookup("midrst_lookup", 1'b0, 32'h404);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BP_STATS_EN
        chk("stat_br_rst", stat_br_cnt, 32'd0);
        chk("stat_mp_rst", stat_mispred_cnt, 32'd0);
        @(negedge clk); drive_ex(1, 32'h100, 1, 0, 0, 32'h104, 32'h104);
        @(negedge clk); drive_ex(1, 32'h104, 1, 0, 0, 32'h108, 32'h108);
        @(negedge clk); drive_ex(1, 32'h108, 1, 1, 0, 32'h040, 32'h10C);
        @(negedge clk); drive_ex(1, 32'h200, 0, 0, 0, 32'h204, 32'h204);
        @(negedge clk); drive_ex(0, 0, 0, 0, 0, 0, 0);
        chk("stat_br", stat_br_cnt, 32'd3);
        chk("stat_mp", stat_mispred_cnt, 32'd1);
        drive_ex(1, 32'h300, 0, 0, 1, 32'h600, 32'h304);
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        chk("stat_br_pre", stat_br_cnt, 32'd4);
        chk("stat_rv_pre", {31'h0, bus.redirect_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("stat_br_midrst", stat_br_cnt, 32'd0);
        chk("stat_mp_midrst", stat_mispred_cnt, 32'd0);
        chk("stat_rv_midrst", {31'h0, bus.redirect_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side next-PC predictor, the consumer end of the execute-stage PC resolution.
- Predicts a direction and target for each fetch PC using a direct-mapped table of 2-bit saturating counters plus a target buffer (BTB).
- Execute stage reports the resolved outcome: is_br, is_br_taken, dnpc and the jump class.
- Block trains its tables from that report and raises a registered redirect when the fetch-time prediction differed from the resolved dnpc.

Parameters:
- ENTRIES, 64, number of table entries; must be a power of two, minimum 4.
- IDX_W, $clog2(ENTRIES), index width. Index = pc[IDX_W+1:2].
- TAG_W, 30-IDX_W, tag width. Tag = pc[31:IDX_W+2].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- f_pc  in  32  fetch PC being looked up this cycle
- f_pred_taken  out  1  prediction: redirect fetch to f_pred_target
- f_pred_target  out  32  predicted target
- f_pred_npc  out  32  f_pred_taken ? f_pred_target : f_pc+4
- ex_valid  in  1  execute report valid this cycle
- ex_pc  in  32  PC of the resolved instruction
- ex_is_br  in  1  conditional branch (PC_B / PC_B_inv)
- ex_is_br_taken  in  1  resolved direction of the conditional branch
- ex_is_jump  in  1  unconditional PC-relative jump (PC_J_pc)
- ex_dnpc  in  32  resolved next PC
- ex_pred_npc  in  32  f_pred_npc carried down the pipeline with the instruction
- redirect_valid  out  1  registered mispredict flush request
- redirect_pc  out  32  registered correct fetch PC

Behaviour:
- Reset (async, rst_n low):
  - all entry valid bits = 0; counters = WNT (2'b01).
  - redirect_valid = 0, redirect_pc = 32'h0.
  - Tag/target arrays need not be reset.
- Counter encoding: SNT=0, WNT=1, WT=2, ST=3. Predict taken iff ctr >= 2.
- Lookup is combinational, zero latency:
  - hit = valid[idx] && tag[idx] == f_pc tag.
  - f_pred_taken = hit && ctr[idx][1].
  - f_pred_target = target[idx] when hit, else f_pc+4.
  - Output is not gated by reset.
- Update happens on the rising edge when ex_valid=1:
  - ex_is_br: on hit, increment the counter if ex_is_br_taken, else decrement, saturating at 3 and 0. On miss, allocate valid=1, tag, target=ex_dnpc only if taken, with ctr=WT; a not-taken miss does not allocate.
  - When taken, target[idx] is always rewritten with ex_dnpc.
  - ex_is_jump: allocate or overwrite with valid=1, tag, target=ex_dnpc, ctr=ST.
  - Neither flag set (snpc, PC_J_reg, PC_EPC, PC_TRAP): tables untouched.
  - ex_is_br and ex_is_jump both set is illegal. Treat it as a jump; an SVA assertion flags it.
- Mispredict check: mispred = ex_valid && (ex_dnpc != ex_pred_npc). This applies to every instruction class, so traps and register jumps also redirect.
- redirect_valid <= mispred and redirect_pc <= ex_dnpc, one cycle after the report. redirect_valid is a single-cycle pulse per mispredict. Back-to-back mispredicts produce back-to-back pulses; the later report wins on each edge.
- Same-index lookup and update in one cycle: the lookup returns the pre-update value, with no bypass.
- Aliasing: a tag mismatch on update is treated as a miss; allocation evicts the old entry.
- Counters saturate; 32-bit additions wrap modulo 2^32. f_pc=32'hFFFF_FFFC gives f_pred_npc=0.
- rst_n asserted mid-operation: all state clears at once, and any pending redirect is dropped.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds output ports stat_br_cnt[31:0] and stat_mispred_cnt[31:0].
  - stat_br_cnt increments on ex_valid && (ex_is_br || ex_is_jump).
  - stat_mispred_cnt increments on mispred.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared defs package/header gains:
  - counter state constants BP_SNT, BP_WNT, BP_WT, BP_ST;
  - the 2-bit counter typedef;
  - BP_ENTRIES_DEFAULT.
- Reuses the existing INST_LENTH for +4.
- One sub-module, bp_sat_ctr: a combinational 2-bit saturating update (ctr, taken) -> next ctr, unit-testable alone.

Test Plan:
- Reset, then lookup f_pc=0x100 -> f_pred_taken=0, f_pred_npc=0x104; redirect_valid=0.
- Report a taken branch: ex_pc=0x100, is_br=1, is_br_taken=1, dnpc=0x80, pred_npc=0x104.
  - Next cycle: redirect_valid=1, redirect_pc=0x80.
  - Then lookup 0x100 -> taken, target 0x80.
- Same entry, two not-taken reports -> counter goes WT->WNT->SNT; lookup 0x100 -> not taken, npc 0x104. A further not-taken report keeps SNT (saturation).
- Jump ex_pc=0x200, is_jump=1, dnpc=0x400 -> ctr=ST.
  - Then a branch at ex_pc=0x200+4*ENTRIES (same index, new tag), taken -> old entry evicted; lookup 0x200 -> miss.
- Correctly predicted report (dnpc == pred_npc) -> no redirect pulse. Two consecutive mispredicts -> redirect_valid high for 2 cycles with the respective PCs.
- With BP_STATS_EN: 3 branches and 1 mispredict -> stat_br_cnt=3, stat_mispred_cnt=1. rst_n low mid-sequence -> both counters 0 and redirect_valid 0 immediately.
